// File: rtl/sc_fetch_unit.sv
// Instruction fetch stage: holds the PC, reads instruction memory over req/ack and strobes the IR.
// Optional request timeout with sticky fault is enabled by defining SC_FETCH_TIMEOUT_EN.
module sc_fetch_unit #(
  parameter int                       DATAWIDTH_BUS  = 32,
  parameter logic [DATAWIDTH_BUS-1:0] RESET_VECTOR   = '0,
  parameter int                       TIMEOUT_CYCLES = 16
) (
  input  logic                     SC_FETCH_CLOCK_50,
  input  logic                     SC_FETCH_RESET_InHigh,
  input  logic                     SC_FETCH_Start_In,
  input  logic                     SC_FETCH_PCLoad_In,
  input  logic [DATAWIDTH_BUS-1:0] SC_FETCH_PCLoadValue_In,
  input  logic                     SC_FETCH_MemAck_In,
  input  logic [DATAWIDTH_BUS-1:0] SC_FETCH_MemData_In,
  output logic                     SC_FETCH_MemReq_Out,
  output logic [DATAWIDTH_BUS-1:0] SC_FETCH_MemAddr_Out,
  output logic                     SC_FETCH_IRWrite_OutLow,
  output logic [DATAWIDTH_BUS-1:0] SC_FETCH_IRData_Out,
  output logic [DATAWIDTH_BUS-1:0] SC_FETCH_PC_Out,
  output logic                     SC_FETCH_Busy_Out,
  output logic                     SC_FETCH_Done_Out,
  output logic                     SC_FETCH_Fault_Out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WRITE
  } state_t;

  localparam logic [DATAWIDTH_BUS-1:0] ALIGN_MASK = ~DATAWIDTH_BUS'(3);
  localparam logic [DATAWIDTH_BUS-1:0] RESET_PC   = RESET_VECTOR & ALIGN_MASK;
  localparam logic [DATAWIDTH_BUS-1:0] PC_STEP    = DATAWIDTH_BUS'(4);

  state_t                   r_state;
  logic [DATAWIDTH_BUS-1:0] r_pc;
  logic [DATAWIDTH_BUS-1:0] r_memAddr;
  logic [DATAWIDTH_BUS-1:0] r_buffer;
  logic [DATAWIDTH_BUS-1:0] w_loadPc;
  logic [DATAWIDTH_BUS-1:0] w_nextPc;

`ifdef SC_FETCH_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_waitCnt;
  logic       r_fault;
`endif

  // A redirect in the same IDLE cycle as Start steers that fetch to the new address.
  assign w_loadPc = SC_FETCH_PCLoadValue_In & ALIGN_MASK;
  assign w_nextPc = SC_FETCH_PCLoad_In ? w_loadPc : r_pc;

  always_ff @(posedge SC_FETCH_CLOCK_50) begin
    if (SC_FETCH_RESET_InHigh) begin
      r_state   <= ST_IDLE;
      r_pc      <= RESET_PC;
      r_memAddr <= RESET_PC;
      r_buffer  <= '0;
`ifdef SC_FETCH_TIMEOUT_EN
      r_waitCnt <= '0;
      r_fault   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (SC_FETCH_PCLoad_In) begin
            r_pc <= w_loadPc;
          end
          if (SC_FETCH_Start_In) begin
            r_memAddr <= w_nextPc;
            r_state   <= ST_REQ;
`ifdef SC_FETCH_TIMEOUT_EN
            r_waitCnt <= '0;
`endif
          end
        end
        ST_REQ: begin
          // An ack on the final allowed cycle still completes the fetch normally.
          if (SC_FETCH_MemAck_In) begin
            r_buffer <= SC_FETCH_MemData_In;
            r_state  <= ST_WRITE;
          end
`ifdef SC_FETCH_TIMEOUT_EN
          else if (r_waitCnt == TIMEOUT_LAST) begin
            r_fault <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_waitCnt <= r_waitCnt + 8'd1;
          end
`endif
        end
        ST_WRITE: begin
          r_pc    <= r_pc + PC_STEP;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are decoded from state alone so MemAck never reaches the IR combinationally.
  assign SC_FETCH_MemReq_Out     = (r_state == ST_REQ);
  assign SC_FETCH_IRWrite_OutLow = (r_state != ST_WRITE);
  assign SC_FETCH_Done_Out       = (r_state == ST_WRITE);
  assign SC_FETCH_Busy_Out       = (r_state != ST_IDLE);
  assign SC_FETCH_MemAddr_Out    = r_memAddr;
  assign SC_FETCH_IRData_Out     = r_buffer;
  assign SC_FETCH_PC_Out         = r_pc;

`ifdef SC_FETCH_TIMEOUT_EN
  assign SC_FETCH_Fault_Out = r_fault;
`else
  assign SC_FETCH_Fault_Out = 1'b0;
`endif

endmodule
